// File: rtl/fp_div_sequencer_pkg.sv
// fp_div_sequencer_pkg
// Shared types and constants for the FPU divide path. It holds the existing
// float_t and fu_state_e types, plus the divide sequencer state type, the
// divide flag struct and the IEEE-754 single-precision special constants.
// The optional special-operand bypass is FP_DIV_SPECIAL_BYPASS_EN. It is
// selected in fp_div_sequencer.sv. This package is the same in both builds.
package fp_div_sequencer_pkg;

  typedef logic [31:0] float_t;

  typedef enum logic [1:0] {
    FU_FREE,
    FU_BUSY,
    FU_DONE
  } fu_state_e;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ISSUE,
    DS_WAIT,
    DS_HOLD
  } div_seq_state_e;

  // Bit order matches the divider flag bus: {overflow, underflow, invalid, zero_divide}
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic zero_divide;
  } fp_div_flags_t;

  localparam float_t Q_NAN   = 32'h7FC0_0000;
  localparam float_t P_INFTY = 32'h7F80_0000;
  localparam float_t N_INFTY = 32'hFF80_0000;
  localparam float_t P_ZERO  = 32'h0000_0000;
  localparam float_t N_ZERO  = 32'h8000_0000;

  localparam int CNT_W = 6;

  function automatic float_t signed_inf(input logic sign);
    return sign ? N_INFTY : P_INFTY;
  endfunction

  function automatic float_t signed_zero(input logic sign);
    return sign ? N_ZERO : P_ZERO;
  endfunction

endpackage

// File: rtl/fp_div_sequencer_if.sv
// fp_div_sequencer_if
// Bundles the request, divider and writeback signals of the divide sequencer.
//   slave  : the sequencer's view (request and divider inputs, launch and
//            writeback outputs, busy/timeout status)
//   master : the surrounding issue stage, divider and writeback view
// Signal names keep the _i/_o suffixes as seen from the sequencer.
interface fp_div_sequencer_if
  import fp_div_sequencer_pkg::*;
#(
  parameter int TAG_W = 5
);

  logic             req_valid_i;
  logic             req_ready_o;
  float_t           req_dividend_i;
  float_t           req_divisor_i;
  logic [TAG_W-1:0] req_tag_i;

  float_t           div_dividend_o;
  float_t           div_divisor_o;
  logic             div_start_o;
  logic             div_free_i;
  logic             div_valid_i;
  float_t           div_result_i;
  fp_div_flags_t    div_flags_i;

  logic             wb_valid_o;
  logic             wb_ready_i;
  float_t           wb_result_o;
  fp_div_flags_t    wb_flags_o;
  logic [TAG_W-1:0] wb_tag_o;

  logic             busy_o;
  logic             timeout_o;

  modport slave (
    input  req_valid_i, req_dividend_i, req_divisor_i, req_tag_i,
    input  div_free_i, div_valid_i, div_result_i, div_flags_i,
    input  wb_ready_i,
    output req_ready_o, div_dividend_o, div_divisor_o, div_start_o,
    output wb_valid_o, wb_result_o, wb_flags_o, wb_tag_o,
    output busy_o, timeout_o
  );

  modport master (
    output req_valid_i, req_dividend_i, req_divisor_i, req_tag_i,
    output div_free_i, div_valid_i, div_result_i, div_flags_i,
    output wb_ready_i,
    input  req_ready_o, div_dividend_o, div_divisor_o, div_start_o,
    input  wb_valid_o, wb_result_o, wb_flags_o, wb_tag_o,
    input  busy_o, timeout_o
  );

endinterface

// File: rtl/fp_div_special_classifier.sv
// fp_div_special_classifier
// Purely combinational detector for divide operands whose result is fixed by
// IEEE-754 rules, so the divider does not need to be launched.
//   dividend, divisor : float_t operands
//   hit               : operands form a special case
//   result, flags     : the fixed result and flags (valid only when hit)
// The sequencer instantiates this block only under FP_DIV_SPECIAL_BYPASS_EN.
module fp_div_special_classifier
  import fp_div_sequencer_pkg::*;
(
  input  float_t        dividend,
  input  float_t        divisor,
  output logic          hit,
  output float_t        result,
  output fp_div_flags_t flags
);

  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;
  logic sign;

  assign a_nan  = (&dividend[30:23]) & (|dividend[22:0]);
  assign a_inf  = (&dividend[30:23]) & ~(|dividend[22:0]);
  assign a_zero = ~(|dividend[30:0]);
  assign b_nan  = (&divisor[30:23]) & (|divisor[22:0]);
  assign b_inf  = (&divisor[30:23]) & ~(|divisor[22:0]);
  assign b_zero = ~(|divisor[30:0]);
  assign sign   = dividend[31] ^ divisor[31];

  // The priority order matters. Invalid cases come first. Then inf/finite
  // is checked, so inf/0 gives a signed infinity without zero_divide. Then
  // x/0, then finite/inf, and last 0/nonzero.
  always_comb begin
    hit    = 1'b1;
    result = Q_NAN;
    flags  = '0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      flags.invalid = 1'b1;
    end else if (a_inf) begin
      result = signed_inf(sign);
    end else if (b_zero) begin
      result            = signed_inf(sign);
      flags.zero_divide = 1'b1;
    end else if (b_inf) begin
      result          = signed_zero(sign);
      flags.underflow = 1'b1;
    end else if (a_zero) begin
      result = signed_zero(sign);
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_sequencer.sv
// fp_div_sequencer
// Issue-side controller for the multicycle FP divider. It accepts one request
// at a time and launches the divider. It then waits for the result under a
// watchdog and holds result/flags/tag until writeback takes them.
//   clk_i, rst_i (sync, active-high), clk_en_i (low freezes all state)
//   bus : fp_div_sequencer_if.slave (request, divider and writeback handshakes)
// Configuration macro FP_DIV_SPECIAL_BYPASS_EN: when defined, special operands
// are resolved at acceptance and go straight to HOLD without using the divider.
module fp_div_sequencer
  import fp_div_sequencer_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int MAX_LAT = 48
)(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clk_en_i,
  fp_div_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LAT - 1);

  div_seq_state_e   state, state_next;
  float_t           dividend_q, divisor_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt_q;
  float_t           result_q;
  fp_div_flags_t    flags_q;
  logic             timeout_q;

  logic accept, start, got_result, abort, wb_done;

  logic          sp_hit;
  float_t        sp_result;
  fp_div_flags_t sp_flags;

`ifdef FP_DIV_SPECIAL_BYPASS_EN
  fp_div_special_classifier u_classifier (
    .dividend (bus.req_dividend_i),
    .divisor  (bus.req_divisor_i),
    .hit      (sp_hit),
    .result   (sp_result),
    .flags    (sp_flags)
  );
`else
  assign sp_hit    = 1'b0;
  assign sp_result = P_ZERO;
  assign sp_flags  = '0;
`endif

  assign accept     = (state == DS_IDLE) & bus.req_valid_i & clk_en_i & ~rst_i;
  assign start      = (state == DS_ISSUE) & bus.div_free_i & clk_en_i;
  assign got_result = (state == DS_WAIT) & bus.div_valid_i;
  // div_valid_i wins over the watchdog in the same cycle.
  assign abort      = (state == DS_WAIT) & ~bus.div_valid_i & (cnt_q == LAST_CNT);
  assign wb_done    = (state == DS_HOLD) & clk_en_i & bus.wb_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= DS_IDLE;
    end else if (clk_en_i) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    bus.req_ready_o = 1'b0;
    bus.div_start_o = 1'b0;
    bus.wb_valid_o  = 1'b0;
    bus.busy_o      = (state != DS_IDLE);
    case (state)
      DS_IDLE: begin
        bus.req_ready_o = clk_en_i & ~rst_i;
        if (accept) state_next = sp_hit ? DS_HOLD : DS_ISSUE;
      end
      DS_ISSUE: begin
        bus.div_start_o = start;
        if (start) state_next = DS_WAIT;
      end
      DS_WAIT: begin
        if (got_result | abort) state_next = DS_HOLD;
      end
      DS_HOLD: begin
        bus.wb_valid_o = clk_en_i;
        if (wb_done) state_next = DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

  // The launch pulse clears the watchdog counter, so the counter is zero in
  // the first WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dividend_q <= P_ZERO;
      divisor_q  <= P_ZERO;
      tag_q      <= '0;
      cnt_q      <= '0;
      result_q   <= P_ZERO;
      flags_q    <= '0;
      timeout_q  <= 1'b0;
    end else if (clk_en_i) begin
      timeout_q <= abort;
      if (accept) begin
        dividend_q <= bus.req_dividend_i;
        divisor_q  <= bus.req_divisor_i;
        tag_q      <= bus.req_tag_i;
        if (sp_hit) begin
          result_q <= sp_result;
          flags_q  <= sp_flags;
        end
      end
      if (start) begin
        cnt_q <= '0;
      end else if (state == DS_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (got_result) begin
        result_q <= bus.div_result_i;
        flags_q  <= bus.div_flags_i;
      end else if (abort) begin
        result_q <= Q_NAN;
        flags_q  <= fp_div_flags_t'(4'b0010);
      end
    end
  end

  assign bus.div_dividend_o = dividend_q;
  assign bus.div_divisor_o  = divisor_q;
  assign bus.wb_result_o    = result_q;
  assign bus.wb_flags_o     = flags_q;
  assign bus.wb_tag_o       = tag_q;
  assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// tb_fp_div_sequencer
// Self-checking bench for fp_div_sequencer. A behavioural divider model
// returns a programmed result after a programmed number of cycles, or never.
// Expected writeback contents and timing follow the sequencer's rules: a
// result appears lat+2 cycles after accept, and the watchdog fires after
// MAX_LAT WAIT cycles. The special-operand section depends on
// FP_DIV_SPECIAL_BYPASS_EN.
module tb_fp_div_sequencer;
  import fp_div_sequencer_pkg::*;

  localparam int TAG_W   = 5;
  localparam int MAX_LAT = 48;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  int n_tests = 0;
  int n_fail  = 0;

  fp_div_sequencer_if #(.TAG_W(TAG_W)) bus ();

  fp_div_sequencer #(.TAG_W(TAG_W), .MAX_LAT(MAX_LAT)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clk_en_i (clk_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Divider model. mdl_lat = 0 means the divider never answers.
  int            mdl_lat   = 0;
  float_t        mdl_res   = '0;
  fp_div_flags_t mdl_flags = '0;
  int            mdl_cnt   = 0;
  int            n_starts  = 0;
  bit            inj_req   = 1'b0;
  bit            inj_ack   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_cnt = 0;
    end else if (bus.div_start_o === 1'b1) begin
      n_starts++;
      mdl_cnt = mdl_lat;
    end else if (mdl_cnt > 0) begin
      mdl_cnt--;
    end
    #1;
    bus.div_valid_i  = 1'b0;
    bus.div_result_i = 32'h0;
    bus.div_flags_i  = '0;
    if (mdl_cnt == 1) begin
      bus.div_valid_i  = 1'b1;
      bus.div_result_i = mdl_res;
      bus.div_flags_i  = mdl_flags;
    end
    if (inj_req != inj_ack) begin
      inj_ack          = inj_req;
      bus.div_valid_i  = 1'b1;
      bus.div_result_i = 32'h1234_5678;
      bus.div_flags_i  = fp_div_flags_t'(4'b1111);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] global timeout");
  end

  function automatic float_t rand_normal();
    float_t f;
    f[31]    = 1'($urandom_range(0, 1));
    f[30:23] = 8'($urandom_range(1, 254));
    f[22:0]  = 23'($urandom);
    return f;
  endfunction

  // Presents a request and returns at the negedge right after the accept edge.
  task automatic send_req(input float_t a, input float_t b, input logic [TAG_W-1:0] t);
    int guard;
    guard = 0;
    bus.req_valid_i    = 1'b1;
    bus.req_dividend_i = a;
    bus.req_divisor_i  = b;
    bus.req_tag_i      = t;
    while (bus.req_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (bus.req_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL send_req: req_ready_o=%b, required 1", bus.req_ready_o);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(output int cycles);
    cycles = 0;
    while (bus.wb_valid_o !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    n_tests++;
    if (bus.wb_valid_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wait_wb: wb_valid_o=%b after %0d cycles, required 1", bus.wb_valid_o, cycles);
    end
  endtask

  task automatic release_wb();
    bus.wb_ready_i = 1'b1;
    @(negedge clk);
    bus.wb_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.req_ready_o, bus.busy_o, bus.wb_valid_o, bus.div_start_o, bus.timeout_o} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: ready/busy/wb_valid/start/timeout=%b, required 00000",
               {bus.req_ready_o, bus.busy_o, bus.wb_valid_o, bus.div_start_o, bus.timeout_o});
    end
    n_tests++;
    if (bus.wb_result_o !== 32'h0 || bus.wb_flags_o !== 4'h0 || bus.wb_tag_o !== 5'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: result=%h flags=%b tag=%0d, required 0/0/0",
               bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: ready=%b busy=%b, required 1/0", bus.req_ready_o, bus.busy_o);
    end
  endtask

  task automatic test_basic();
    int s0, cyc;
    mdl_lat = 30; mdl_res = 32'h4040_0000; mdl_flags = '0;
    bus.div_free_i = 1'b1;
    s0 = n_starts;
    send_req(32'h40C0_0000, 32'h4000_0000, 5'd3);
    n_tests++;
    if (bus.div_start_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_start: start=%b busy=%b, required 1/1", bus.div_start_o, bus.busy_o);
    end
    n_tests++;
    if (bus.div_dividend_o !== 32'h40C0_0000 || bus.div_divisor_o !== 32'h4000_0000) begin
      n_fail++;
      $display("[TB] FAIL basic_operands: %h/%h, required 40c00000/40000000",
               bus.div_dividend_o, bus.div_divisor_o);
    end
    wait_wb(cyc);
    n_tests++;
    if (cyc != 31) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: %0d cycles after ISSUE, required 31", cyc);
    end
    n_tests++;
    if (bus.wb_result_o !== 32'h4040_0000 || bus.wb_tag_o !== 5'd3 || bus.wb_flags_o !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL basic_wb: result=%h tag=%0d flags=%b, required 40400000/3/0000",
               bus.wb_result_o, bus.wb_tag_o, bus.wb_flags_o);
    end
    n_tests++;
    if (n_starts - s0 != 1) begin
      n_fail++;
      $display("[TB] FAIL basic_start_count: %0d launches, required 1", n_starts - s0);
    end
    release_wb();
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_idle: busy=%b ready=%b, required 0/1", bus.busy_o, bus.req_ready_o);
    end
  endtask

  task automatic test_wb_stall();
    for (int it = 0; it < 4; it++) begin
      int lat, cyc, stall, s0;
      float_t a, b, res;
      fp_div_flags_t fl;
      logic [TAG_W-1:0] tag;
      lat = $urandom_range(3, 20);
      a = rand_normal(); b = rand_normal();
      res = $urandom; fl = fp_div_flags_t'(4'($urandom_range(0, 15)));
      tag = TAG_W'($urandom_range(0, 31));
      mdl_lat = lat; mdl_res = res; mdl_flags = fl;
      stall = (it == 0) ? 10 : $urandom_range(0, 4);
      s0 = n_starts;
      send_req(a, b, tag);
      n_tests++;
      if (bus.div_dividend_o !== a || bus.div_divisor_o !== b) begin
        n_fail++;
        $display("[TB] FAIL stall_operands: %h/%h, required %h/%h", bus.div_dividend_o, bus.div_divisor_o, a, b);
      end
      wait_wb(cyc);
      n_tests++;
      if (cyc != lat + 1) begin
        n_fail++;
        $display("[TB] FAIL stall_latency: %0d cycles, required %0d", cyc, lat + 1);
      end
      for (int k = 0; k <= stall; k++) begin
        n_tests++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== res || bus.wb_flags_o !== fl ||
            bus.wb_tag_o !== tag || bus.req_ready_o !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stall_hold: valid=%b result=%h flags=%b tag=%0d ready=%b, required 1/%h/%b/%0d/0",
                   bus.wb_valid_o, bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o, bus.req_ready_o, res, fl, tag);
        end
        if (k < stall) @(negedge clk);
      end
      release_wb();
      n_tests++;
      if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1 || n_starts - s0 != 1) begin
        n_fail++;
        $display("[TB] FAIL stall_release: busy=%b ready=%b launches=%0d, required 0/1/1",
                 bus.busy_o, bus.req_ready_o, n_starts - s0);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic [TAG_W-1:0] tag;
    tag = TAG_W'($urandom_range(0, 31));
    mdl_lat = 0;
    send_req(rand_normal(), rand_normal(), tag);
    cyc = 0;
    while (bus.timeout_o !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != MAX_LAT + 1) begin
      n_fail++;
      $display("[TB] FAIL timeout_cycle: timeout after %0d cycles, required %0d", cyc, MAX_LAT + 1);
    end
    n_tests++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_result_o !== 32'h7FC0_0000 || bus.wb_flags_o !== 4'b0010 ||
        bus.wb_tag_o !== tag) begin
      n_fail++;
      $display("[TB] FAIL timeout_wb: valid=%b result=%h flags=%b tag=%0d, required 1/7fc00000/0010/%0d",
               bus.wb_valid_o, bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o, tag);
    end
    @(negedge clk);
    n_tests++;
    if (bus.timeout_o !== 1'b0 || bus.wb_valid_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout_pulse: timeout=%b wb_valid=%b, required 0/1", bus.timeout_o, bus.wb_valid_o);
    end
    release_wb();
  endtask

  task automatic test_free_and_enable();
    int cyc, s0;
    bus.div_free_i = 1'b0;
    mdl_lat = 0;
    s0 = n_starts;
    send_req(rand_normal(), rand_normal(), 5'd9);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (bus.div_start_o !== 1'b0 || bus.busy_o !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL free_low: start=%b busy=%b, required 0/1", bus.div_start_o, bus.busy_o);
      end
      @(negedge clk);
    end
    bus.div_free_i = 1'b1;
    #1;
    n_tests++;
    if (bus.div_start_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL free_start: start=%b, required 1", bus.div_start_o);
    end
    @(negedge clk);
    cyc = 1;
    repeat (9) begin @(negedge clk); cyc++; end
    clk_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      cyc++;
      n_tests++;
      if ({bus.req_ready_o, bus.div_start_o, bus.wb_valid_o, bus.timeout_o, bus.busy_o} !== 5'b00001) begin
        n_fail++;
        $display("[TB] FAIL enable_freeze: ready/start/wb_valid/timeout/busy=%b, required 00001",
                 {bus.req_ready_o, bus.div_start_o, bus.wb_valid_o, bus.timeout_o, bus.busy_o});
      end
    end
    clk_en = 1'b1;
    while (bus.timeout_o !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != MAX_LAT + 1 + 6) begin
      n_fail++;
      $display("[TB] FAIL enable_watchdog: timeout after %0d cycles, required %0d", cyc, MAX_LAT + 7);
    end
    n_tests++;
    if (n_starts - s0 != 1) begin
      n_fail++;
      $display("[TB] FAIL free_start_count: %0d launches, required 1", n_starts - s0);
    end
    release_wb();
  endtask

  task automatic test_special();
`ifdef FP_DIV_SPECIAL_BYPASS_EN
    float_t ta [8] = '{32'h3F80_0000, 32'hC040_0000, 32'h0000_0000, 32'h7FC0_0001,
                       32'h7F80_0000, 32'h4000_0000, 32'h8000_0000, 32'hFF80_0000};
    float_t tb [8] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000,
                       32'hFF80_0000, 32'hFF80_0000, 32'h40A0_0000, 32'h4000_0000};
    float_t tr [8] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                       32'h7FC0_0000, 32'h8000_0000, 32'h8000_0000, 32'hFF80_0000};
    logic [3:0] tf [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      int s0;
      logic [TAG_W-1:0] tag;
      tag = TAG_W'($urandom_range(0, 31));
      s0 = n_starts;
      send_req(ta[i], tb[i], tag);
      n_tests++;
      if (bus.wb_valid_o !== 1'b1 || bus.div_start_o !== 1'b0 || bus.wb_result_o !== tr[i] ||
          bus.wb_flags_o !== tf[i] || bus.wb_tag_o !== tag) begin
        n_fail++;
        $display("[TB] FAIL bypass_%0d: valid=%b start=%b result=%h flags=%b tag=%0d, required 1/0/%h/%b/%0d",
                 i, bus.wb_valid_o, bus.div_start_o, bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o,
                 tr[i], tf[i], tag);
      end
      release_wb();
      n_tests++;
      if (n_starts != s0 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bypass_nolaunch_%0d: launches=%0d busy=%b, required 0/0", i, n_starts - s0, bus.busy_o);
      end
    end
`else
    int s0, cyc;
    mdl_lat = 8; mdl_res = 32'h7F80_0000; mdl_flags = fp_div_flags_t'(4'b0001);
    s0 = n_starts;
    send_req(32'h3F80_0000, 32'h0000_0000, 5'd17);
    n_tests++;
    if (bus.div_start_o !== 1'b1 || bus.wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL nobypass_start: start=%b wb_valid=%b, required 1/0", bus.div_start_o, bus.wb_valid_o);
    end
    wait_wb(cyc);
    n_tests++;
    if (cyc != 9 || bus.wb_result_o !== 32'h7F80_0000 || bus.wb_flags_o !== 4'b0001 ||
        bus.wb_tag_o !== 5'd17 || n_starts - s0 != 1) begin
      n_fail++;
      $display("[TB] FAIL nobypass_wb: cyc=%0d result=%h flags=%b tag=%0d launches=%0d, required 9/7f800000/0001/17/1",
               cyc, bus.wb_result_o, bus.wb_flags_o, bus.wb_tag_o, n_starts - s0);
    end
    release_wb();
`endif
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    float_t res;
    mdl_lat = 0;
    send_req(rand_normal(), rand_normal(), 5'd21);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.wb_valid_o !== 1'b0 || bus.wb_result_o !== 32'h0 || bus.timeout_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_state: busy=%b wb_valid=%b result=%h timeout=%b, required 0/0/0/0",
               bus.busy_o, bus.wb_valid_o, bus.wb_result_o, bus.timeout_o);
    end
    inj_req = ~inj_req;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (bus.wb_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midreset_late_valid: wb_valid=%b busy=%b, required 0/0", bus.wb_valid_o, bus.busy_o);
      end
    end
    res = $urandom;
    mdl_lat = 6; mdl_res = res; mdl_flags = '0;
    send_req(rand_normal(), rand_normal(), 5'd22);
    wait_wb(cyc);
    n_tests++;
    if (cyc != 7 || bus.wb_result_o !== res || bus.wb_tag_o !== 5'd22) begin
      n_fail++;
      $display("[TB] FAIL midreset_next_op: cyc=%0d result=%h tag=%0d, required 7/%h/22",
               cyc, bus.wb_result_o, bus.wb_tag_o, res);
    end
    release_wb();
  endtask

  task automatic test_back_to_back();
    int cyc;
    float_t a2, res2;
    a2 = rand_normal(); res2 = $urandom;
    mdl_lat = 4; mdl_res = $urandom; mdl_flags = '0;
    send_req(rand_normal(), rand_normal(), 5'd1);
    wait_wb(cyc);
    bus.wb_ready_i     = 1'b1;
    bus.req_valid_i    = 1'b1;
    bus.req_dividend_i = a2;
    bus.req_divisor_i  = rand_normal();
    bus.req_tag_i      = 5'd2;
    @(negedge clk);
    bus.wb_ready_i = 1'b0;
    mdl_res = res2;
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_bubble: busy=%b ready=%b, required 0/1", bus.busy_o, bus.req_ready_o);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    n_tests++;
    if (bus.div_start_o !== 1'b1 || bus.div_dividend_o !== a2) begin
      n_fail++;
      $display("[TB] FAIL b2b_issue: start=%b dividend=%h, required 1/%h", bus.div_start_o, bus.div_dividend_o, a2);
    end
    wait_wb(cyc);
    n_tests++;
    if (cyc != 5 || bus.wb_result_o !== res2 || bus.wb_tag_o !== 5'd2) begin
      n_fail++;
      $display("[TB] FAIL b2b_wb: cyc=%0d result=%h tag=%0d, required 5/%h/2", cyc, bus.wb_result_o, bus.wb_tag_o, res2);
    end
    release_wb();
  endtask

  initial begin
    rst                = 1'b1;
    clk_en             = 1'b1;
    bus.req_valid_i    = 1'b0;
    bus.req_dividend_i = '0;
    bus.req_divisor_i  = '0;
    bus.req_tag_i      = '0;
    bus.div_free_i     = 1'b1;
    bus.wb_ready_i     = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wb_stall();
    test_timeout();
    test_free_and_enable();
    test_special();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_sequencer.md
# fp_div_sequencer

Issue-side controller for the multicycle floating-point divide unit. Accepts divide requests over a valid/ready handshake and launches one operation at a time on the divider. Waits for its result with a watchdog, then holds the result, flags and destination tag until writeback accepts them. Sits between the FPU issue stage and the divider; with the configuration macro set, it also resolves special operands without launching the divider.

## Interface
- TAG_W, 5: width of destination tag (register index)
- MAX_LAT, 48: watchdog limit, WAIT cycles before abort; must exceed divider worst-case latency
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clk_en_i  in  1  global clock enable; low freezes all state
- req_valid_i / req_ready_o  in / out  1 / 1  request handshake
- req_dividend_i, req_divisor_i  in  32 each  float_t operands
- req_tag_i  in  TAG_W  destination tag
- div_dividend_o, div_divisor_o  out  32 each  operands to divider, stable from ISSUE through WAIT
- div_start_o  out  1  one-cycle launch pulse
- div_free_i  in  1  divider reports FREE
- div_valid_i  in  1  divider result valid, one-cycle pulse
- div_result_i  in  32  divider result
- div_flags_i  in  4  {overflow, underflow, invalid, zero_divide}
- wb_valid_o / wb_ready_i  out / in  1 / 1  writeback handshake
- wb_result_o  out  32  result
- wb_flags_o  out  4  flags, same order as div_flags_i
- wb_tag_o  out  TAG_W  tag
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on watchdog abort

## Operation
- States:
  - IDLE → ISSUE on request accept.
  - ISSUE → WAIT when div_start_o fires.
  - WAIT → HOLD on div_valid_i or watchdog abort.
  - HOLD → IDLE on writeback accept.
- req_ready_o = (state == IDLE) & clk_en_i. Accept means req_valid_i & req_ready_o at a rising edge; operands and tag are registered at that edge.
- ISSUE: div_start_o = div_free_i & clk_en_i. Stays in ISSUE while div_free_i is low.
- WAIT:
  - The 6-bit cycle counter clears on entry and increments each enabled cycle.
  - On div_valid_i, capture div_result_i and div_flags_i.
  - Abort when the counter equals MAX_LAT-1 with div_valid_i low: result 0x7FC00000, flags 4'b0010, timeout_o pulses.
  - div_valid_i and the abort condition in the same cycle: div_valid_i wins, no timeout.
- HOLD: wb_valid_o = clk_en_i. Output registers stay stable until wb_valid_o & wb_ready_i.
- div_valid_i outside WAIT is ignored.
- All register updates require clk_en_i. With clk_en_i low, req_ready_o, div_start_o and wb_valid_o are low and no handshake completes.
- Reset values: state IDLE; req_ready_o 0 during reset then 1; div_start_o 0; wb_valid_o 0; wb_result_o 0; wb_flags_o 0; wb_tag_o 0; busy_o 0; timeout_o 0; counter 0.
- Reset mid-operation drops the op without a writeback. The divider has its own reset, and any later div_valid_i is ignored.

## Timing
- Request accepted at edge N → ISSUE in cycle N+1, div_start_o high in N+1 if div_free_i.
- div_valid_i sampled at edge K → wb_valid_o from cycle K+1.
- End-to-end latency = divider latency + 2 cycles, plus stall cycles.
- Writeback accepted at edge M → IDLE at M+1. Next request can be accepted at edge M+1, so there is one bubble between back-to-back ops.
- Abort: timeout_o and wb_valid_o both rise in the cycle after the abort edge.

## Configuration
- FP_DIV_SPECIAL_BYPASS_EN defined:
  - Operands are classified combinationally at acceptance. Special cases go IDLE → HOLD directly (latency 1) and never pulse div_start_o.
  - NaN operand, 0/0 or ∞/∞: 0x7FC00000, flags invalid.
  - Nonzero finite / 0: signed ∞, flags zero_divide.
  - Finite / ∞: signed zero, flags underflow.
  - 0 / nonzero: signed zero, no flags.
  - ∞ / finite: signed ∞, no flags.
  - Sign is the XOR of the operand signs.
- Undefined: every request goes through the divider; the classifier is not built.

## Structure
- Shared package, alongside the existing float_t and fu_state_e:
  - div_seq_state_e
  - fp_div_flags_t packed struct {overflow, underflow, invalid, zero_divide}
  - the Q_NAN, P_INFTY, N_INFTY, P_ZERO and N_ZERO constants
- One sub-module: fp_div_special_classifier, purely combinational. It returns hit, result and flags, and is instantiated only under FP_DIV_SPECIAL_BYPASS_EN.

## Test plan
- 6.0/2.0, tag 3, divider model returns after 30 cycles → div_start_o pulses once; wb_result_o 0x40400000, wb_tag_o 3, flags 0.
- Result ready with wb_ready_i low for 10 cycles → outputs stable, req_ready_o 0; accept then IDLE next cycle.
- Divider never returns → timeout_o pulses at cycle MAX_LAT of WAIT; wb_result_o 0x7FC00000, flags 4'b0010.
- div_free_i low 5 cycles in ISSUE → div_start_o delayed 5 cycles; clk_en_i low mid-WAIT freezes counter and handshakes.
- Bypass enabled, 1.0/0.0 → no div_start_o; wb_valid_o next cycle with 0x7F800000, zero_divide. Macro off → same op goes through divider.
- rst_i asserted in WAIT, late div_valid_i follows → IDLE, wb_valid_o stays 0; next request completes normally.
